// File: rtl/mxint_block_normalizer.sv
// Re-quantizes a block of wide MXINT mantissas sharing one exponent into narrow
// mantissas with an adjusted shared exponent. Three-stage valid/ready pipeline:
// S1 measures per-element magnitude width, S2 picks the shift and new exponent,
// S3 rounds, saturates and handles exponent overflow.
module mxint_block_normalizer #(
  parameter int unsigned BLOCK_SIZE    = 4,
  parameter int unsigned IN_MAN_WIDTH  = 24,
  parameter int unsigned IN_EXP_WIDTH  = 4,
  parameter int unsigned OUT_MAN_WIDTH = 8,
  parameter int unsigned OUT_EXP_WIDTH = IN_EXP_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]     mdata_in_0,
  input  logic [IN_EXP_WIDTH-1:0]                     edata_in_0,
  input  logic                                        data_in_0_valid,
  output logic                                        data_in_0_ready,
  output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]    mdata_out_0,
  output logic [OUT_EXP_WIDTH-1:0]                    edata_out_0,
  output logic                                        data_out_0_valid,
  input  logic                                        data_out_0_ready
);

  // Magnitude-bit count never exceeds IN_MAN_WIDTH-1.
  localparam int unsigned LW = $clog2(IN_MAN_WIDTH + 1);
  // Working exponent is wide enough that e + shift never wraps.
  localparam int unsigned EW = OUT_EXP_WIDTH + LW + 1;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << (OUT_EXP_WIDTH - 1)) - 1);
  localparam logic signed [IN_MAN_WIDTH:0] MMAX =
      (IN_MAN_WIDTH + 1)'((1 << (OUT_MAN_WIDTH - 1)) - 1);
  localparam logic signed [IN_MAN_WIDTH:0] MMIN = ~MMAX;
  localparam logic [OUT_MAN_WIDTH-1:0] OMAX = {1'b0, {(OUT_MAN_WIDTH - 1){1'b1}}};
  localparam logic [OUT_MAN_WIDTH-1:0] OMIN = {1'b1, {(OUT_MAN_WIDTH - 1){1'b0}}};

  logic ready1, ready2, ready3;
  logic v1_q, v2_q, v3_q;

  logic [BLOCK_SIZE-1:0][IN_MAN_WIDTH-1:0]  s1_man_q, s2_man_q;
  logic [IN_EXP_WIDTH-1:0]                  s1_exp_q;
  logic [BLOCK_SIZE-1:0][LW-1:0]            s1_len_q, s1_len_d;
  logic [IN_MAN_WIDTH-1:0]                  s1_mag [BLOCK_SIZE];

  logic [LW-1:0]                            s2_lmax, s2_shift_d, s2_shift_q;
  logic [EW-1:0]                            s2_enew_d, s2_enew_q;

  logic [IN_MAN_WIDTH:0]                    s3_sum [BLOCK_SIZE];
  logic signed [IN_MAN_WIDTH:0]             s3_r   [BLOCK_SIZE];
  logic                                     s3_ovf;
  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0] s3_man_d, s3_man_q;
  logic [OUT_EXP_WIDTH-1:0]                 s3_exp_d, s3_exp_q;

  // Handshake chain: a stage loads when empty or when its successor moves.
  always_comb begin
    ready3 = !v3_q || data_out_0_ready;
    ready2 = !v2_q || ready3;
    ready1 = !v1_q || ready2;
  end

  assign data_in_0_ready  = ready1;
  assign data_out_0_valid = v3_q;
  assign mdata_out_0      = s3_man_q;
  assign edata_out_0      = s3_exp_q;

  // S1: magnitude bits = bit length of m XOR its sign (so 0 and -1 give 0).
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      s1_mag[i]   = mdata_in_0[i] ^ {IN_MAN_WIDTH{mdata_in_0[i][IN_MAN_WIDTH-1]}};
      s1_len_d[i] = '0;
      for (int b = 0; b < IN_MAN_WIDTH; b++) begin
        if (s1_mag[i][b]) s1_len_d[i] = LW'(b + 1);
      end
    end
  end

  // S2: largest magnitude sets the right shift; exponent only ever grows.
  always_comb begin
    s2_lmax = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      if (s1_len_q[i] > s2_lmax) s2_lmax = s1_len_q[i];
    end
    s2_shift_d = (s2_lmax > LW'(OUT_MAN_WIDTH - 1)) ? s2_lmax - LW'(OUT_MAN_WIDTH - 1) : '0;
    s2_enew_d  = {{(EW - IN_EXP_WIDTH){s1_exp_q[IN_EXP_WIDTH-1]}}, s1_exp_q}
               + {{(EW - LW){1'b0}}, s2_shift_d};
  end

  // S3: round half up, saturate, and clamp everything on exponent overflow.
  always_comb begin
    s3_ovf   = $signed(s2_enew_q) > EMAX;
    s3_exp_d = s3_ovf ? EMAX[OUT_EXP_WIDTH-1:0] : s2_enew_q[OUT_EXP_WIDTH-1:0];
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      s3_sum[i] = {s2_man_q[i][IN_MAN_WIDTH-1], s2_man_q[i]};
      if (s2_shift_q != '0) begin
        s3_sum[i] = s3_sum[i] + ((IN_MAN_WIDTH + 1)'(1) << (s2_shift_q - 1'b1));
      end
      s3_r[i] = $signed(s3_sum[i]) >>> s2_shift_q;
      if (s3_ovf) begin
        if (s2_man_q[i] == '0)                   s3_man_d[i] = '0;
        else if (s2_man_q[i][IN_MAN_WIDTH-1])    s3_man_d[i] = OMIN;
        else                                     s3_man_d[i] = OMAX;
      end else if (s3_r[i] > MMAX) begin
        s3_man_d[i] = OMAX;
      end else if (s3_r[i] < MMIN) begin
        s3_man_d[i] = OMIN;
      end else begin
        s3_man_d[i] = s3_r[i][OUT_MAN_WIDTH-1:0];
      end
    end
  end

  // Pipeline registers with synchronous reset discarding all in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      s1_man_q   <= '0;
      s1_exp_q   <= '0;
      s1_len_q   <= '0;
      s2_man_q   <= '0;
      s2_shift_q <= '0;
      s2_enew_q  <= '0;
      s3_man_q   <= '0;
      s3_exp_q   <= '0;
    end else begin
      if (ready1) begin
        v1_q <= data_in_0_valid;
        if (data_in_0_valid) begin
          s1_man_q <= mdata_in_0;
          s1_exp_q <= edata_in_0;
          s1_len_q <= s1_len_d;
        end
      end
      if (ready2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_man_q   <= s1_man_q;
          s2_shift_q <= s2_shift_d;
          s2_enew_q  <= s2_enew_d;
        end
      end
      if (ready3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          s3_man_q <= s3_man_d;
          s3_exp_q <= s3_exp_d;
        end
      end
    end
  end

endmodule
